// File: rtl/bottle_pkg.sv
// Shared types and constants for the bottle fill controller.
package bottle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_SETTLE,
    S_ADVANCE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CFG      = 2'd1;
  localparam logic [1:0] ERR_OVERFILL = 2'd2;
  localparam logic [1:0] ERR_CONV_TMO = 2'd3;

endpackage

// File: rtl/sensor_sync.sv
// Two-flop synchroniser for an asynchronous sensor, followed by a registered
// rising-edge detect that yields a one-cycle event.
module sensor_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
      rise   <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/bottle_fill_ctrl.sv
// Tablet bottle-filling sequencer: counts tablets into each bottle, checks for
// overfill during a settle window, then advances the conveyor to the next bottle.
module bottle_fill_ctrl
  import bottle_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned ADV_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clr_err,
  input  logic       tablet_pulse,
  input  logic       bip,
  input  logic [5:0] cfg_tabs,
  input  logic [3:0] cfg_bottles,
  output logic       feeder_en,
  output logic       conveyor_en,
  output logic       busy,
  output logic       done,
  output logic [5:0] tab_cnt,
  output logic [3:0] bottle_cnt,
  output logic [1:0] err_code
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned AW = (ADV_TIMEOUT > 1) ? $clog2(ADV_TIMEOUT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [AW-1:0] ADV_LAST    = AW'(ADV_TIMEOUT - 1);

  state_t        state;
  logic [5:0]    tgt_tabs;
  logic [3:0]    tgt_bottles;
  logic [SW-1:0] settle_cnt;
  logic [AW-1:0] adv_cnt;
  logic          tab_ev;
  logic          bip_ev;
  logic [5:0]    tab_inc;
  logic [3:0]    bottle_inc;

  sensor_sync u_tab_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (tablet_pulse),
    .rise     (tab_ev)
  );

  // A synchronised rising edge of bip is by construction a low-then-high sequence.
  sensor_sync u_bip_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (bip),
    .rise     (bip_ev)
  );

  assign tab_inc    = tab_cnt + 6'd1;
  assign bottle_inc = bottle_cnt + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      feeder_en   <= 1'b0;
      conveyor_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tab_cnt     <= '0;
      bottle_cnt  <= '0;
      err_code    <= ERR_NONE;
      tgt_tabs    <= '0;
      tgt_bottles <= '0;
      settle_cnt  <= '0;
      adv_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end

        S_LOAD: begin
          tgt_tabs    <= cfg_tabs;
          tgt_bottles <= cfg_bottles;
          tab_cnt     <= '0;
          bottle_cnt  <= '0;
          if (cfg_tabs == '0 || cfg_bottles == '0) begin
            state    <= S_ERROR;
            err_code <= ERR_CFG;
            busy     <= 1'b0;
          end else begin
            state     <= S_FILL;
            err_code  <= ERR_NONE;
            feeder_en <= !pause;
          end
        end

        S_FILL: begin
          feeder_en <= !pause;
          if (tab_ev) begin
            tab_cnt <= tab_inc;
            if (tab_inc == tgt_tabs) begin
              state      <= S_SETTLE;
              feeder_en  <= 1'b0;
              settle_cnt <= '0;
            end
          end
        end

        S_SETTLE: begin
          if (tab_ev) begin
            tab_cnt  <= tab_inc;
            err_code <= ERR_OVERFILL;
            state    <= S_ERROR;
            busy     <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state       <= S_ADVANCE;
            conveyor_en <= !pause;
            adv_cnt     <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        S_ADVANCE: begin
          conveyor_en <= !pause;
          if (bip_ev) begin
            bottle_cnt  <= bottle_inc;
            tab_cnt     <= '0;
            conveyor_en <= 1'b0;
            if (bottle_inc == tgt_bottles) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= S_FILL;
              feeder_en <= !pause;
            end
          end else if (!pause) begin
            if (adv_cnt == ADV_LAST) begin
              state       <= S_ERROR;
              err_code    <= ERR_CONV_TMO;
              conveyor_en <= 1'b0;
              busy        <= 1'b0;
            end else begin
              adv_cnt <= adv_cnt + 1'b1;
            end
          end
        end

        S_ERROR: begin
          feeder_en   <= 1'b0;
          conveyor_en <= 1'b0;
          if (clr_err) begin
            state    <= S_IDLE;
            err_code <= ERR_NONE;
          end
        end

        default: begin
          state       <= S_IDLE;
          feeder_en   <= 1'b0;
          conveyor_en <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Directed self-checking bench for bottle_fill_ctrl: nominal batch, pause,
// overfill, bad config, conveyor timeout and asynchronous reset.
module tb_bottle_fill_ctrl;

  logic       clk          = 1'b0;
  logic       reset        = 1'b1;
  logic       start        = 1'b0;
  logic       pause        = 1'b0;
  logic       clr_err      = 1'b0;
  logic       tablet_pulse = 1'b0;
  logic       bip          = 1'b0;
  logic [5:0] cfg_tabs     = '0;
  logic [3:0] cfg_bottles  = '0;
  logic       feeder_en;
  logic       conveyor_en;
  logic       busy;
  logic       done;
  logic [5:0] tab_cnt;
  logic [3:0] bottle_cnt;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bottle_fill_ctrl #(
    .SETTLE_CYC  (6),
    .ADV_TIMEOUT (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pause        (pause),
    .clr_err      (clr_err),
    .tablet_pulse (tablet_pulse),
    .bip          (bip),
    .cfg_tabs     (cfg_tabs),
    .cfg_bottles  (cfg_bottles),
    .feeder_en    (feeder_en),
    .conveyor_en  (conveyor_en),
    .busy         (busy),
    .done         (done),
    .tab_cnt      (tab_cnt),
    .bottle_cnt   (bottle_cnt),
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse high for two clocks; the count reflects it when this returns.
  task automatic pulse();
    tablet_pulse = 1'b1;
    tick(2);
    tablet_pulse = 1'b0;
    tick(2);
  endtask

  initial begin
    tick(2);
    chk("reset_outputs", {18'd0, feeder_en, conveyor_en, busy, done, tab_cnt, bottle_cnt, err_code}, 32'd0);
    reset = 1'b0;

    // Nominal batch: 3 tablets x 2 bottles
    cfg_tabs = 6'd3;
    cfg_bottles = 4'd2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_feeder_off", feeder_en, 0);
    tick(1);
    chk("fill_feeder_on", feeder_en, 1);
    chk("fill_tab_zero", tab_cnt, 0);

    tablet_pulse = 1'b1;
    tick(2);
    tablet_pulse = 1'b0;
    tick(1);
    chk("tab_latency_e3", tab_cnt, 0);
    tick(1);
    chk("tab_latency_e4", tab_cnt, 1);
    pulse();
    chk("tab_two", tab_cnt, 2);
    chk("feeder_still_on", feeder_en, 1);
    pulse();
    chk("tab_target", tab_cnt, 3);
    chk("settle_feeder_off", feeder_en, 0);
    chk("settle_busy", busy, 1);
    tick(5);
    chk("settle_conv_off", conveyor_en, 0);
    tick(1);
    chk("advance_conv_on", conveyor_en, 1);

    bip = 1'b1;
    tick(3);
    chk("bottle1_pending", bottle_cnt, 0);
    chk("conv_still_on", conveyor_en, 1);
    tick(1);
    chk("bottle1_count", bottle_cnt, 1);
    chk("bottle1_tab_clr", tab_cnt, 0);
    chk("refill_feeder_on", feeder_en, 1);
    chk("refill_conv_off", conveyor_en, 0);
    bip = 1'b0;

    pulse();
    pulse();
    pulse();
    chk("b2_tab_target", tab_cnt, 3);
    tick(6);
    chk("b2_advance_conv", conveyor_en, 1);
    bip = 1'b1;
    tick(4);
    chk("batch_done", done, 1);
    chk("batch_bottles", bottle_cnt, 2);
    chk("batch_err", err_code, 0);
    chk("batch_busy", busy, 0);
    chk("batch_conv_off", conveyor_en, 0);
    chk("batch_tab_clr", tab_cnt, 0);
    bip = 1'b0;
    pulse();
    tick(3);
    chk("done_held", done, 1);
    chk("done_ignores_tab", tab_cnt, 0);

    // Pause in FILL, then overfill during SETTLE
    cfg_tabs = 6'd2;
    cfg_bottles = 4'd1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("restart_done_clr", done, 0);
    chk("restart_busy", busy, 1);
    tick(1);
    chk("restart_bottle_clr", bottle_cnt, 0);
    chk("restart_feeder_on", feeder_en, 1);
    pause = 1'b1;
    tick(1);
    chk("pause_feeder_off", feeder_en, 0);
    pulse();
    chk("pause_tab_counted", tab_cnt, 1);
    chk("pause_feeder_still_off", feeder_en, 0);
    pause = 1'b0;
    tick(1);
    chk("unpause_feeder_on", feeder_en, 1);
    pulse();
    chk("of_tab_target", tab_cnt, 2);
    chk("of_feeder_off", feeder_en, 0);
    pulse();
    chk("of_err_code", err_code, 2);
    chk("of_tab_cnt", tab_cnt, 3);
    chk("of_feeder_off_err", feeder_en, 0);
    chk("of_busy", busy, 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("err_ignores_start_busy", busy, 0);
    chk("err_ignores_start_code", err_code, 2);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("of_clr_err", err_code, 0);

    // Bad configuration
    cfg_tabs = 6'd3;
    cfg_bottles = 4'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("cfg_load_busy", busy, 1);
    tick(1);
    chk("cfg_err_code", err_code, 1);
    chk("cfg_busy", busy, 0);
    chk("cfg_feeder_off", feeder_en, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("cfg_clr_err", err_code, 0);

    // Conveyor timeout with bip stuck high
    bip = 1'b1;
    tick(4);
    cfg_tabs = 6'd1;
    cfg_bottles = 4'd1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    pulse();
    chk("tmo_tab", tab_cnt, 1);
    tick(6);
    chk("tmo_conv_on", conveyor_en, 1);
    tick(19);
    chk("tmo_conv_before", conveyor_en, 1);
    chk("tmo_err_before", err_code, 0);
    tick(1);
    chk("tmo_err_code", err_code, 3);
    chk("tmo_conv_off", conveyor_en, 0);
    chk("tmo_busy", busy, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("tmo_clr_err", err_code, 0);

    // Pause in ADVANCE, then reset mid-ADVANCE
    bip = 1'b0;
    cfg_tabs = 6'd1;
    cfg_bottles = 4'd2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    pulse();
    tick(6);
    chk("rst_adv_conv_on", conveyor_en, 1);
    pause = 1'b1;
    tick(1);
    chk("adv_pause_conv_off", conveyor_en, 0);
    pause = 1'b0;
    tick(1);
    chk("adv_unpause_conv_on", conveyor_en, 1);
    reset = 1'b1;
    #1;
    chk("rst_async_outputs", {18'd0, feeder_en, conveyor_en, busy, done, tab_cnt, bottle_cnt, err_code}, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("rst_no_resume", {busy, feeder_en, conveyor_en}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
